// File: rtl/cbus_arbiter_n_if.sv
// Cache-bus request/response types and the bundle joining N requesters, the
// arbiter and the downstream AXI adapter.
package cbus_pkg;
    typedef enum logic [2:0] {
        MLEN1 = 3'd0,
        MLEN2 = 3'd1,
        MLEN4 = 3'd3,
        MLEN8 = 3'd7
    } cbus_len_e;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        cbus_len_e   len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [7:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;
endpackage

interface cbus_arbiter_n_if #(
    parameter int NUM_PORTS = 2
);
    import cbus_pkg::*;

    // Handshake: a requester raises valid and holds valid plus its address,
    // len, size, burst and is_write stable until it sees a beat with both
    // ready and last; a beat transfers on every cycle with ready=1, and
    // dropping valid before that last beat aborts the burst.
    cbus_req_t  [NUM_PORTS-1:0] ireqs;
    cbus_resp_t [NUM_PORTS-1:0] oresps;
    cbus_req_t                  oreq;
    cbus_resp_t                 iresp;

    modport slave  (input ireqs, input iresp, output oresps, output oreq);
    modport master (output ireqs, output iresp, input oresps, input oreq);
endinterface

// File: rtl/cbus_arbiter_n.sv
// N-to-1 cache-bus arbiter: picks one requester (round-robin or fixed
// priority), then passes its burst through until last or abort.
module cbus_arbiter_n
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int IDX_W       = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cbus_arbiter_n_if.slave      bus,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_idx,
    output arb_state_e           dbg_state,
    output logic [IDX_W-1:0]     dbg_prio
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     prio_q, prio_d;
    logic [NUM_PORTS-1:0] valid_vec;
    logic [IDX_W-1:0]     win_hi, win_lo, winner;
    logic                 found_hi;
    cbus_req_t            sel_req;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_valid
        assign valid_vec[i] = bus.ireqs[i].valid;
    end

    // Rotating priority as two scans: the lowest valid index at or above prio
    // wins, otherwise the search wraps to the lowest valid index overall.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (valid_vec[i]) begin
                win_lo = IDX_W'(i);
                if (IDX_W'(i) >= prio_q) begin
                    win_hi   = IDX_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        winner = (ROUND_ROBIN && found_hi) ? win_hi : win_lo;
    end

    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) sel_req = bus.ireqs[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        prio_d   = prio_q;
        busy     = 1'b0;
        bus.oreq = '0;
        for (int i = 0; i < NUM_PORTS; i++) bus.oresps[i] = '0;

        case (state_q)
            ARB_IDLE: begin
                if (|valid_vec) begin
                    grant_d = winner;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                busy     = 1'b1;
                bus.oreq = sel_req;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (grant_q == IDX_W'(i)) bus.oresps[i] = bus.iresp;
                end
                // Burst ends on the last accepted beat, or early when the owner drops valid.
                if ((bus.iresp.ready && bus.iresp.last) || !sel_req.valid) begin
                    state_d = ARB_IDLE;
                    if (ROUND_ROBIN) begin
                        prio_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

    assign grant_idx = grant_q;
    assign dbg_state = state_q;
    assign dbg_prio  = prio_q;

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Bench for cbus_arbiter_n: a 5-port round-robin and a 3-port fixed-priority
// instance, both checked every cycle against an ownership/pointer model.
module tb_cbus_arbiter_n;
    import cbus_pkg::*;

    localparam int NA = 5;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    cbus_req_t  req_d [2][8];
    cbus_resp_t resp_d [2];

    cbus_arbiter_n_if #(.NUM_PORTS(NA)) bus_a ();
    cbus_arbiter_n_if #(.NUM_PORTS(NB)) bus_b ();

    logic       busy_a, busy_b;
    logic [2:0] gidx_a, prio_a;
    logic [1:0] gidx_b, prio_b;
    arb_state_e st_a, st_b;

    cbus_arbiter_n #(.NUM_PORTS(NA), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .reset_n(reset_n), .bus(bus_a), .busy(busy_a),
        .grant_idx(gidx_a), .dbg_state(st_a), .dbg_prio(prio_a)
    );
    cbus_arbiter_n #(.NUM_PORTS(NB), .ROUND_ROBIN(1'b0)) u_fp (
        .clk(clk), .reset_n(reset_n), .bus(bus_b), .busy(busy_b),
        .grant_idx(gidx_b), .dbg_state(st_b), .dbg_prio(prio_b)
    );

    cbus_req_t  oreq_o [2];
    cbus_resp_t oresp_o [2][8];
    logic       busy_o [2];
    int         gidx_o [2];
    int         prio_o [2];
    arb_state_e st_o [2];

    assign bus_a.iresp = resp_d[0];
    assign bus_b.iresp = resp_d[1];
    assign oreq_o[0]   = bus_a.oreq;
    assign oreq_o[1]   = bus_b.oreq;

    for (genvar i = 0; i < 8; i++) begin : g_wire
        if (i < NA) begin : g_a
            assign bus_a.ireqs[i] = req_d[0][i];
            assign oresp_o[0][i]  = bus_a.oresps[i];
        end else begin : g_a0
            assign oresp_o[0][i] = '0;
        end
        if (i < NB) begin : g_b
            assign bus_b.ireqs[i] = req_d[1][i];
            assign oresp_o[1][i]  = bus_b.oresps[i];
        end else begin : g_b0
            assign oresp_o[1][i] = '0;
        end
    end

    always_comb begin
        busy_o[0] = busy_a;
        busy_o[1] = busy_b;
        gidx_o[0] = int'(gidx_a);
        gidx_o[1] = int'(gidx_b);
        prio_o[0] = int'(prio_a);
        prio_o[1] = int'(prio_b);
        st_o[0]   = st_a;
        st_o[1]   = st_b;
    end

    // Reference model: who owns the bus (-1 = nobody) and where the next
    // round-robin search starts.
    int owner [2];
    int ptr   [2];
    bit active [2][8];
    int np [2] = '{NA, NB};
    bit rr [2] = '{1'b1, 1'b0};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic cbus_req_t mk(input logic [31:0] addr, input cbus_len_e len,
                                     input logic wr, input logic [63:0] data);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.len      = len;
        r.size     = 3'd3;
        r.burst    = 2'd1;
        r.data     = data;
        r.strobe   = wr ? 8'hFF : 8'h00;
        return r;
    endfunction

    function automatic cbus_resp_t mkr(input logic rdy, input logic lst, input logic [63:0] data);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = data;
        return r;
    endfunction

    function automatic int pick(input int d);
        for (int k = 0; k < np[d]; k++) begin
            int j;
            j = rr[d] ? (ptr[d] + k) % np[d] : k;
            if (req_d[d][j].valid) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1;
            ptr[d]   = 0;
            for (int p = 0; p < 8; p++) active[d][p] = 1'b0;
        end
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            resp_d[d] = '0;
            for (int p = 0; p < 8; p++) req_d[d][p] = '0;
        end
    endtask

    task automatic check_dut(input int d);
        cbus_req_t  er;
        cbus_resp_t ers;
        er = '0;
        if (owner[d] >= 0) er = req_d[d][owner[d]];
        chk($sformatf("oreq_d%0d", d), 256'(oreq_o[d]), 256'(er));
        for (int p = 0; p < np[d]; p++) begin
            ers = (p == owner[d]) ? resp_d[d] : '0;
            chk($sformatf("oresp_d%0d_p%0d", d, p), 256'(oresp_o[d][p]), 256'(ers));
        end
        chk($sformatf("busy_d%0d", d), 256'(busy_o[d]), 256'(owner[d] >= 0));
        chk($sformatf("state_d%0d", d), 256'(st_o[d]), 256'((owner[d] >= 0) ? ARB_BUSY : ARB_IDLE));
        chk($sformatf("prio_d%0d", d), 256'(prio_o[d]), 256'(ptr[d]));
        if (owner[d] >= 0) chk($sformatf("gidx_d%0d", d), 256'(gidx_o[d]), 256'(owner[d]));
    endtask

    task automatic advance(input int d);
        if (owner[d] < 0) begin
            owner[d] = pick(d);
        end else if ((resp_d[d].ready && resp_d[d].last) || !req_d[d][owner[d]].valid) begin
            if (resp_d[d].ready && resp_d[d].last) active[d][owner[d]] = 1'b0;
            if (rr[d]) ptr[d] = (owner[d] + 1) % np[d];
            owner[d] = -1;
        end
    endtask

    // Called #1 after a falling edge with inputs already driven.
    task automatic tick();
        check_dut(0);
        check_dut(1);
        advance(0);
        advance(1);
        @(negedge clk);
    endtask

    task automatic cyc();
        #1;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        chk("rst_gidx_a", 256'(gidx_o[0]), 256'(0));
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_inputs(input int d);
        cbus_len_e l;
        for (int p = 0; p < np[d]; p++) begin
            if (active[d][p]) begin
                if ($urandom_range(0, 24) == 0) begin
                    active[d][p]       = 1'b0;
                    req_d[d][p].valid  = 1'b0;
                end else begin
                    req_d[d][p].data   = {$urandom, $urandom};
                    req_d[d][p].strobe = 8'($urandom);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       l = MLEN1;
                    1:       l = MLEN2;
                    2:       l = MLEN4;
                    default: l = MLEN8;
                endcase
                active[d][p] = 1'b1;
                req_d[d][p]  = mk($urandom, l, 1'($urandom_range(0, 1)), {$urandom, $urandom});
            end else begin
                req_d[d][p] = '0;
            end
        end
        resp_d[d] = mkr(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), {$urandom, $urandom});
    endtask

    initial begin
        int got_a[$];
        int got_b[$];

        // Single read burst on port 1 of the round-robin instance
        do_reset();
        req_d[0][1] = mk(32'h8000_0040, MLEN4, 1'b0, 64'h0);
        #1;
        chk("s1_first_cycle_valid", 256'(oreq_o[0].valid), 256'(0));
        tick();
        for (int b = 0; b < 4; b++) begin
            resp_d[0] = mkr(1'b1, (b == 3), 64'hA0 + 64'(b));
            #1;
            chk("s1_addr", 256'(oreq_o[0].addr), 256'(32'h8000_0040));
            chk("s1_resp_data", 256'(oresp_o[0][1].data), 256'(64'hA0 + 64'(b)));
            tick();
        end
        req_d[0][1] = '0;
        resp_d[0]   = '0;
        #1;
        chk("s1_busy_after_last", 256'(busy_o[0]), 256'(0));
        chk("s1_prio", 256'(prio_o[0]), 256'(2));
        tick();

        // Round-robin fairness (instance a) and fixed priority (instance b)
        do_reset();
        for (int p = 0; p < 3; p++) req_d[0][p] = mk(32'h1000 + 32'(p * 64), MLEN1, 1'b0, 64'h0);
        req_d[1][0] = mk(32'h4000, MLEN1, 1'b0, 64'h0);
        req_d[1][2] = mk(32'h4080, MLEN1, 1'b0, 64'h0);
        resp_d[0] = mkr(1'b1, 1'b1, 64'h55);
        resp_d[1] = mkr(1'b1, 1'b1, 64'h66);
        for (int c = 0; c < 12; c++) begin
            #1;
            if (busy_o[0]) got_a.push_back(gidx_o[0]);
            if (busy_o[1]) got_b.push_back(gidx_o[1]);
            tick();
        end
        chk("rr_grant_count", 256'(got_a.size()), 256'(6));
        for (int i = 0; i < got_a.size(); i++) chk($sformatf("rr_order_%0d", i), 256'(got_a[i]), 256'(i % 3));
        chk("fp_grant_count", 256'(got_b.size()), 256'(6));
        for (int i = 0; i < got_b.size(); i++) chk($sformatf("fp_port0_%0d", i), 256'(got_b[i]), 256'(0));
        req_d[1][0] = '0;
        cyc();
        #1;
        chk("fp_port2_busy", 256'(busy_o[1]), 256'(1));
        chk("fp_port2_grant", 256'(gidx_o[1]), 256'(2));
        tick();

        // Write burst with per-beat data
        do_reset();
        req_d[0][0] = mk(32'h2000, MLEN2, 1'b1, 64'h1111);
        cyc();
        resp_d[0] = mkr(1'b1, 1'b0, 64'h0);
        #1;
        chk("wr_beat0_data", 256'(oreq_o[0].data), 256'(64'h1111));
        chk("wr_beat0_strb", 256'(oreq_o[0].strobe), 256'(8'hFF));
        tick();
        req_d[0][0].data = 64'h2222;
        resp_d[0] = mkr(1'b1, 1'b1, 64'h0);
        #1;
        chk("wr_beat1_data", 256'(oreq_o[0].data), 256'(64'h2222));
        chk("wr_beat1_busy", 256'(busy_o[0]), 256'(1));
        tick();
        req_d[0][0] = '0;
        resp_d[0]   = '0;
        #1;
        chk("wr_busy_clear", 256'(busy_o[0]), 256'(0));
        tick();

        // Abort by the highest port and pointer wrap
        do_reset();
        req_d[0][2] = mk(32'h5000, MLEN1, 1'b0, 64'h0);
        resp_d[0]   = mkr(1'b1, 1'b1, 64'h0);
        cyc();
        cyc();
        req_d[0][2] = '0;
        resp_d[0]   = '0;
        req_d[0][4] = mk(32'h6000, MLEN4, 1'b0, 64'h0);
        #1;
        chk("ab_prio_before", 256'(prio_o[0]), 256'(3));
        tick();
        #1;
        chk("ab_grant4", 256'(gidx_o[0]), 256'(4));
        tick();
        req_d[0][4].valid = 1'b0;
        #1;
        chk("ab_oreq_valid", 256'(oreq_o[0].valid), 256'(0));
        tick();
        req_d[0][0] = mk(32'h7000, MLEN1, 1'b0, 64'h0);
        req_d[0][3] = mk(32'h7100, MLEN1, 1'b0, 64'h0);
        #1;
        chk("ab_idle", 256'(busy_o[0]), 256'(0));
        chk("ab_prio_wrap", 256'(prio_o[0]), 256'(0));
        tick();
        #1;
        chk("ab_grant0", 256'(gidx_o[0]), 256'(0));
        tick();

        // Asynchronous reset in the middle of a long read
        do_reset();
        req_d[0][1] = mk(32'h3000, MLEN8, 1'b0, 64'h0);
        cyc();
        resp_d[0] = mkr(1'b1, 1'b0, 64'h11);
        cyc();
        resp_d[0] = mkr(1'b1, 1'b0, 64'h22);
        #1;
        chk("ar_busy_before", 256'(busy_o[0]), 256'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_busy", 256'(busy_o[0]), 256'(0));
        chk("ar_oreq", 256'(oreq_o[0]), 256'(0));
        chk("ar_oresp1", 256'(oresp_o[0][1]), 256'(0));
        chk("ar_prio", 256'(prio_o[0]), 256'(0));
        model_reset();
        @(negedge clk);
        reset_n   = 1'b1;
        resp_d[0] = '0;
        cyc();
        #1;
        chk("ar_regrant", 256'(gidx_o[0]), 256'(1));
        chk("ar_regrant_prio", 256'(prio_o[0]), 256'(0));
        tick();

        // Random traffic on both instances
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rand_inputs(0);
            rand_inputs(1);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
